// File: rtl/dso_disp_pkg.sv
// rtl/dso_disp_pkg.sv - shared display geometry, colours and render FSM states
package dso_disp_pkg;

    localparam int WIN_W  = 300;
    localparam int WIN_H  = 256;
    localparam int GRID_H = 25;
    localparam int GRID_V = 32;

    localparam logic [23:0] COL_WAVE = 24'hFFFF00;
    localparam logic [23:0] COL_TRIG = 24'hFF0000;
    localparam logic [23:0] COL_GRID = 24'h404040;
    localparam logic [23:0] COL_BG   = 24'h000000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REFRESH = 2'd1,
        ST_FETCH   = 2'd2
    } render_state_e;

    // Vertical span between two adjacent samples, packed {hi, lo}.
    function automatic logic [15:0] pack_span(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? {a, b} : {b, a};
    endfunction

endpackage

// File: rtl/wave_line_buf.sv
// rtl/wave_line_buf.sv - 300x16 simple dual-port line buffer with registered read
module wave_line_buf
    import dso_disp_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [8:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [8:0]  raddr,
    output logic [15:0] rdata
);

    // Contents deliberately survive reset; buf_valid in the parent gates their use.
    logic [15:0] mem [WIN_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dso_wave_render.sv
// rtl/dso_wave_render.sv - waveform fetch FSM and 2-stage oscilloscope pixel renderer
module dso_wave_render
    import dso_disp_pkg::*;
#(
    parameter logic [10:0] H_START = 11'd40,
    parameter logic [10:0] V_START = 11'd60
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        frame_start,
    input  logic        wave_run,
    input  logic [7:0]  trig_level,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic        pixel_de,
    output logic        ram_refresh,
    output logic [9:0]  wave_rd_addr,
    input  logic [7:0]  wave_rd_data,
    output logic [23:0] pix_rgb,
    output logic        pix_de
);

    localparam logic [8:0]  LAST_ADDR = 9'(WIN_W - 1);
    localparam logic [8:0]  FETCH_END = 9'(WIN_W);
    localparam logic [10:0] WIN_W11   = 11'(WIN_W);
    localparam logic [10:0] WIN_H11   = 11'(WIN_H);
    localparam logic [4:0]  MOD_LAST  = 5'(GRID_H - 1);
    localparam logic [7:0]  ROW_MASK  = 8'(GRID_V - 1);

    render_state_e state, state_nxt;
    logic [8:0]  fetch_cnt;
    logic [7:0]  prev_sample;
    logic        buf_valid;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [15:0] wr_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ram_refresh = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start && wave_run) begin
                    state_nxt = ST_REFRESH;
                end
            end
            ST_REFRESH: begin
                ram_refresh = 1'b1;
                state_nxt   = ST_FETCH;
            end
            ST_FETCH: begin
                if (fetch_cnt == FETCH_END) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read data lags the address by one clock, so entry k is written while fetch_cnt == k+1.
    always_comb begin
        wave_rd_addr = '0;
        if (state == ST_FETCH && fetch_cnt <= LAST_ADDR) begin
            wave_rd_addr = {1'b0, fetch_cnt};
        end
        wr_en   = (state == ST_FETCH) && (fetch_cnt != 9'd0);
        wr_addr = fetch_cnt - 9'd1;
        wr_data = (fetch_cnt == 9'd1) ? {wave_rd_data, wave_rd_data}
                                      : pack_span(wave_rd_data, prev_sample);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_cnt   <= '0;
            prev_sample <= '0;
            buf_valid   <= 1'b0;
        end else begin
            fetch_cnt <= (state == ST_FETCH) ? fetch_cnt + 9'd1 : 9'd0;
            if (wr_en) begin
                prev_sample <= wave_rd_data;
                if (wr_addr == LAST_ADDR) begin
                    buf_valid <= 1'b1;
                end
            end
        end
    end

    // Stage 0: window decode, column modulo counter, line buffer read issue.
    logic [10:0] col_full;
    logic [10:0] row_off;
    logic        in_win;
    logic [7:0]  r_now;
    logic [4:0]  mod_cnt;
    logic [4:0]  col_mod;
    logic [8:0]  rd_addr;
    logic [15:0] line_rd;

    always_comb begin
        col_full = pixel_x - H_START;
        row_off  = pixel_y - V_START;
        in_win   = (pixel_x >= H_START) && (col_full < WIN_W11) &&
                   (pixel_y >= V_START) && (row_off < WIN_H11);
        r_now    = 8'd255 - row_off[7:0];
        col_mod  = (pixel_de && pixel_x == H_START) ? 5'd0 : mod_cnt;
        rd_addr  = in_win ? col_full[8:0] : 9'd0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mod_cnt <= '0;
        end else if (pixel_de) begin
            mod_cnt <= (col_mod == MOD_LAST) ? 5'd0 : col_mod + 5'd1;
        end
    end

    wave_line_buf u_line_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (line_rd)
    );

    // Stage 1: registered decode alongside the line buffer read data.
    logic       s1_de;
    logic       s1_win;
    logic [7:0] s1_r;
    logic       s1_col_grid;
    logic [23:0] colour;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_de       <= 1'b0;
            s1_win      <= 1'b0;
            s1_r        <= '0;
            s1_col_grid <= 1'b0;
        end else begin
            s1_de       <= pixel_de;
            s1_win      <= in_win;
            s1_r        <= r_now;
            s1_col_grid <= (col_mod == 5'd0);
        end
    end

    always_comb begin
        colour = COL_BG;
        if (!s1_de || !s1_win) begin
            colour = COL_BG;
        end else if (buf_valid && s1_r >= line_rd[7:0] && s1_r <= line_rd[15:8]) begin
            colour = COL_WAVE;
        end else if (s1_r == trig_level) begin
            colour = COL_TRIG;
        end else if (s1_col_grid || (s1_r & ROW_MASK) == 8'd0) begin
            colour = COL_GRID;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_rgb <= '0;
            pix_de  <= 1'b0;
        end else begin
            pix_rgb <= colour;
            pix_de  <= s1_de;
        end
    end

endmodule

// File: tb/tb_dso_wave_render.sv
// tb/tb_dso_wave_render.sv - randomized self-checking bench for dso_wave_render
module tb_dso_wave_render;

    localparam int H = 40;
    localparam int V = 60;

    logic        clk = 1'b0;
    logic        rstn;
    logic        frame_start;
    logic        wave_run;
    logic [7:0]  trig_level;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        pixel_de;
    logic        ram_refresh;
    logic [9:0]  wave_rd_addr;
    logic [7:0]  wave_rd_data;
    logic [23:0] pix_rgb;
    logic        pix_de;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram_pending [300];
    logic [7:0] ram_cur     [300];
    int         model_hi    [300];
    int         model_lo    [300];
    bit         model_valid = 1'b0;
    int         saved_rows  [4];

    dso_wave_render #(.H_START(11'd40), .V_START(11'd60)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .frame_start  (frame_start),
        .wave_run     (wave_run),
        .trig_level   (trig_level),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_de     (pixel_de),
        .ram_refresh  (ram_refresh),
        .wave_rd_addr (wave_rd_addr),
        .wave_rd_data (wave_rd_data),
        .pix_rgb      (pix_rgb),
        .pix_de       (pix_de)
    );

    always #5 clk = ~clk;

    // Capture store: one-clock read latency from the latched waveform image.
    always @(posedge clk) wave_rd_data <= ram_cur[wave_rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void build_model();
        for (int i = 0; i < 300; i++) begin
            int s = int'(ram_cur[i]);
            int p = (i == 0) ? s : int'(ram_cur[i-1]);
            model_hi[i] = (s > p) ? s : p;
            model_lo[i] = (s > p) ? p : s;
        end
    endfunction

    function automatic logic [24:0] ref_pix(input int x, input int y, input bit de);
        int col, r;
        if (!de) return 25'h0;
        if (x < H || x >= H + 300 || y < V || y >= V + 256) return {1'b1, 24'h000000};
        col = x - H;
        r   = 255 - (y - V);
        if (model_valid && r >= model_lo[col] && r <= model_hi[col]) return {1'b1, 24'hFFFF00};
        if (r == int'(trig_level)) return {1'b1, 24'hFF0000};
        if (col % 25 == 0 || r % 32 == 0) return {1'b1, 24'h404040};
        return {1'b1, 24'h000000};
    endfunction

    task automatic render_row(input int y);
        logic [24:0] expq[$];
        for (int n = 0; n < 308; n++) begin
            @(posedge clk); #1;
            if (n < 306) begin
                pixel_x  = 11'(H - 3 + n);
                pixel_y  = 11'(y);
                pixel_de = 1'b1;
                expq.push_back(ref_pix(H - 3 + n, y, 1'b1));
            end else begin
                pixel_x  = '0;
                pixel_de = 1'b0;
                expq.push_back(ref_pix(0, y, 1'b0));
            end
            @(negedge clk);
            if (expq.size() == 3) check("pix", {7'd0, pix_de, pix_rgb}, {7'd0, expq.pop_front()});
        end
    endtask

    task automatic render_r(input int r);
        render_row(V + 255 - r);
    endtask

    // Runs one frame_start; optionally pulses a second frame_start or drops wave_run mid-fetch.
    task automatic run_frame(input bit run, input int dup_at, input int drop_at);
        int errs = 0;
        int extra = 0;
        @(negedge clk);
        wave_run    = run;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        if (!run) begin
            for (int k = 0; k < 310; k++) begin
                if (ram_refresh) extra++;
                @(negedge clk);
            end
            check("frozen_refresh", extra, 0);
            return;
        end
        check("refresh_hi", ram_refresh, 1);
        for (int i = 0; i < 300; i++) ram_cur[i] = ram_pending[i];
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            frame_start = (k == dup_at);
            if (k == drop_at) wave_run = 1'b0;
            if (ram_refresh) extra++;
            if (wave_rd_addr != 10'(k)) errs++;
        end
        @(negedge clk);
        frame_start = 1'b0;
        if (ram_refresh) extra++;
        check("valid_before_end", dut.buf_valid, model_valid);
        @(negedge clk);
        check("valid_after_fetch", dut.buf_valid, 1);
        check("addr_idle", wave_rd_addr, 0);
        for (int k = 0; k < 6; k++) begin
            if (ram_refresh) extra++;
            @(negedge clk);
        end
        check("addr_seq_errs", errs, 0);
        check("single_refresh", extra, 0);
        model_valid = 1'b1;
        build_model();
        wave_run = 1'b1;
    endtask

    task automatic reset_mid_fetch();
        int guard = 0;
        @(negedge clk);
        wave_run    = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        while (wave_rd_addr != 10'd150 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("reach_addr150", guard < 400, 1);
        rstn = 1'b0;
        #1;
        check("rst_refresh", ram_refresh, 0);
        check("rst_addr", wave_rd_addr, 0);
        check("rst_rgb", pix_rgb, 0);
        check("rst_de", pix_de, 0);
        check("rst_valid", dut.buf_valid, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        model_valid = 1'b0;
    endtask

    initial begin
        rstn        = 1'b0;
        frame_start = 1'b0;
        wave_run    = 1'b1;
        trig_level  = 8'd128;
        pixel_x     = '0;
        pixel_y     = '0;
        pixel_de    = 1'b0;
        for (int i = 0; i < 300; i++) begin
            ram_pending[i] = 8'(i);
            ram_cur[i]     = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_refresh", ram_refresh, 0);
        check("reset_addr", wave_rd_addr, 0);
        check("reset_rgb", pix_rgb, 0);
        check("reset_de", pix_de, 0);
        check("reset_valid", dut.buf_valid, 0);
        rstn = 1'b1;

        // Empty buffer: trigger marker, grid and window edges only.
        render_r(128);
        render_r(0);
        render_r(32);
        render_r(77);
        render_row(V - 1);
        render_row(V + 256);

        // Ramp waveform.
        run_frame(1'b1, -1, -1);
        render_r(9);
        render_r(10);
        render_r(0);
        render_r(255);
        render_r(int'($urandom_range(1, 254)));

        // Random waveform; second frame_start and wave_run drop mid-fetch are ignored.
        for (int i = 0; i < 300; i++) ram_pending[i] = 8'($urandom_range(0, 255));
        run_frame(1'b1, 100, 60);
        for (int j = 0; j < 4; j++) begin
            saved_rows[j] = int'($urandom_range(0, 255));
            trig_level    = 8'($urandom_range(0, 255));
            render_r(saved_rows[j]);
        end

        // Frozen: new capture data must not reach the display.
        for (int i = 0; i < 300; i++) ram_pending[i] = 8'($urandom_range(0, 255));
        run_frame(1'b0, -1, -1);
        wave_run = 1'b1;
        for (int j = 0; j < 4; j++) render_r(saved_rows[j]);

        // Reset mid-fetch: no waveform until the next full fetch.
        reset_mid_fetch();
        trig_level = 8'($urandom_range(0, 255));
        render_r(int'($urandom_range(0, 255)));
        render_r(64);
        run_frame(1'b1, -1, -1);
        for (int j = 0; j < 3; j++) begin
            trig_level = 8'($urandom_range(0, 255));
            render_r(int'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
